// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//
// Self-test controller for the 2x4-decoder function block
// F = (AB' + A'B)(C + D'). The sweep applies all 16 ABCD codes in order
// (A is bit 3) and holds each one for SETTLE_CYCLES cycles. It then samples F
// for one cycle and builds a 16-bit truth table, which it compares with
// EXPECTED.
//
// Optional feature, macro TTS_STUCK_FLAG_EN:
//   Adds the 'stuck' output. It is set at done when the captured table is
//   all zeros or all ones, which means F is stuck at a constant.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a sweep (taken in IDLE or DONE only)
//   f_in       in   datapath output F
//   abcd_out   out  [3:0] datapath inputs {A,B,C,D}, registered
//   busy       out  high while a sweep is in progress
//   done       out  one-cycle pulse when the sweep completes
//   table_out  out  [15:0] captured truth table, bit i = F for code i
//   match      out  table_out == EXPECTED, valid from done onward
//   cur_index  out  [3:0] code currently applied
//   state_dbg  out  [1:0] FSM state (0 IDLE, 1 SETTLE, 2 SAMPLE, 3 DONE)
//   stuck      out  F stuck-at flag (only with TTS_STUCK_FLAG_EN)
//
// Handshake: start is a request with no ready signal. The sweep accepts it
// on any rising edge where the FSM is in IDLE or DONE, and drops it silently
// otherwise. busy is high from the accepting edge until the sweep completes.
// done marks completion for exactly one cycle.
module truth_table_sweeper #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = 16'h0DD0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f_in,
  output logic [3:0]  abcd_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic        match,
  output logic [3:0]  cur_index,
  output logic [1:0]  state_dbg
`ifdef TTS_STUCK_FLAG_EN
  ,
  output logic        stuck
`endif
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("truth_table_sweeper: SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] table_q, table_d;
  logic [15:0] sampled_table;
  logic        match_q, match_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef TTS_STUCK_FLAG_EN
  logic        stuck_q, stuck_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    table_d = table_q;
    match_d = match_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef TTS_STUCK_FLAG_EN
    stuck_d = stuck_q;
`endif
    // Table with the current code's bit replaced by F. match and stuck are
    // judged on this table, so bit 15 is included at the DONE edge.
    sampled_table         = table_q;
    sampled_table[idx_q]  = f_in;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SETTLE;
          cnt_d   = RELOAD;
          idx_d   = 4'd0;
          table_d = 16'h0000;
          match_d = 1'b0;
          busy_d  = 1'b1;
`ifdef TTS_STUCK_FLAG_EN
          stuck_d = 1'b0;
`endif
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) state_d = S_SAMPLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_SAMPLE: begin
        table_d = sampled_table;
        if (idx_q == 4'd15) begin
          // Last code: stay on 4'hF and finish without wrapping.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          match_d = (sampled_table == EXPECTED);
`ifdef TTS_STUCK_FLAG_EN
          stuck_d = (sampled_table == 16'h0000) || (sampled_table == 16'hFFFF);
`endif
        end else begin
          state_d = S_SETTLE;
          idx_d   = idx_q + 4'd1;
          cnt_d   = RELOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 4'd0;
      table_q <= 16'h0000;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TTS_STUCK_FLAG_EN
      stuck_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef TTS_STUCK_FLAG_EN
      stuck_q <= stuck_d;
`endif
    end
  end

  // The applied code and the index are one register seen under two names.
  assign abcd_out  = idx_q;
  assign cur_index = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign match     = match_q;
  assign state_dbg = state_q;
`ifdef TTS_STUCK_FLAG_EN
  assign stuck     = stuck_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        f_in;
  logic [3:0]  abcd_out;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic        match;
  logic [3:0]  cur_index;
  logic [1:0]  state_dbg;
`ifdef TTS_STUCK_FLAG_EN
  logic        stuck;
`endif

  int total;
  int bad;
  // 0: reference F, 1: F also forced high for code 5, 2: F tied low
  int f_mode;

  truth_table_sweeper #(.SETTLE_CYCLES(2), .EXPECTED(16'h0DD0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .f_in(f_in),
    .abcd_out(abcd_out),
    .busy(busy),
    .done(done),
    .table_out(table_out),
    .match(match),
    .cur_index(cur_index),
    .state_dbg(state_dbg)
`ifdef TTS_STUCK_FLAG_EN
    ,
    .stuck(stuck)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference datapath: F = (A xor B) & (C | ~D), with A = bit 3.
  function automatic logic ref_f(input logic [3:0] c);
    return (c[3] ^ c[2]) & (c[1] | ~c[0]);
  endfunction

  always_comb begin
    f_in = 1'b0;
    if (f_mode == 0)      f_in = ref_f(abcd_out);
    else if (f_mode == 1) f_in = ref_f(abcd_out) | (abcd_out == 4'd5);
    else                  f_in = 1'b0;
  end

  // ---------------- driver ----------------
  // Runs one sweep and counts cycles from the start-sampling edge (cycle 0).
  // extra_at: cycle whose edge sees an extra start pulse (0 = none).
  task automatic run_sweep(input bit do_pulse, input int extra_at, input int last_n,
                           output int done_at, output int done_cnt, output int step_errs);
    done_at = -1;
    done_cnt = 0;
    step_errs = 0;
    if (do_pulse) begin
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      if (abcd_out !== 4'd0 || busy !== 1'b1) step_errs++;
    end
    for (int n = 1; n <= last_n; n++) begin
      @(negedge clk); start = (n == extra_at);
      @(posedge clk); #1;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (n < 48) begin
        if (abcd_out !== 4'(n / 3) || cur_index !== 4'(n / 3) || busy !== 1'b1) step_errs++;
      end else if (n == 48) begin
        if (busy !== 1'b0 || abcd_out !== 4'hF) step_errs++;
      end
    end
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit busy_seen;
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (abcd_out !== 4'd0) begin bad++; $display("FAIL reset_abcd got=%h want=0", abcd_out); end
    total++; if (cur_index !== 4'd0) begin bad++; $display("FAIL reset_index got=%h want=0", cur_index); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (table_out !== 16'h0000) begin bad++; $display("FAIL reset_table got=%h want=0000", table_out); end
    total++; if (match !== 1'b0) begin bad++; $display("FAIL reset_match got=%b want=0", match); end
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
`ifdef TTS_STUCK_FLAG_EN
    total++; if (stuck !== 1'b0) begin bad++; $display("FAIL reset_stuck got=%b want=0", stuck); end
`endif
    @(negedge clk); rst_n = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || done !== 1'b0) busy_seen = 1'b1;
    end
    total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL idle_busy_rose got=%b want=0", busy_seen); end
    total++; if ({abcd_out, table_out, match} !== 21'd0) begin bad++; $display("FAIL idle_outputs got=%h want=0", {abcd_out, table_out, match}); end
  endtask

  task automatic test_correct();
    int d_at, d_cnt, errs;
    f_mode = 0;
    run_sweep(1'b1, 0, 52, d_at, d_cnt, errs);
    total++; if (d_at !== 48) begin bad++; $display("FAIL correct_latency got=%0d want=48", d_at); end
    total++; if (d_cnt !== 1) begin bad++; $display("FAIL correct_done_count got=%0d want=1", d_cnt); end
    total++; if (errs !== 0) begin bad++; $display("FAIL correct_steps got=%0d want=0", errs); end
    total++; if (table_out !== 16'h0DD0) begin bad++; $display("FAIL correct_table got=%h want=0dd0", table_out); end
    total++; if (match !== 1'b1) begin bad++; $display("FAIL correct_match got=%b want=1", match); end
    total++; if (abcd_out !== 4'hF) begin bad++; $display("FAIL correct_abcd_hold got=%h want=f", abcd_out); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL correct_idle got=%b%b want=00", busy, done); end
`ifdef TTS_STUCK_FLAG_EN
    total++; if (stuck !== 1'b0) begin bad++; $display("FAIL correct_stuck got=%b want=0", stuck); end
`endif
  endtask

  task automatic test_fault();
    int d_at, d_cnt, errs;
    f_mode = 1;
    run_sweep(1'b1, 0, 52, d_at, d_cnt, errs);
    total++; if (d_at !== 48) begin bad++; $display("FAIL fault_latency got=%0d want=48", d_at); end
    total++; if (table_out !== 16'h0DF0) begin bad++; $display("FAIL fault_table got=%h want=0df0", table_out); end
    total++; if (match !== 1'b0) begin bad++; $display("FAIL fault_match got=%b want=0", match); end
    f_mode = 0;
  endtask

  task automatic test_start_while_busy();
    int d_at, d_cnt, errs;
    f_mode = 0;
    run_sweep(1'b1, 20, 48, d_at, d_cnt, errs);
    total++; if (d_at !== 48) begin bad++; $display("FAIL busy_start_latency got=%0d want=48", d_at); end
    total++; if (d_cnt !== 1) begin bad++; $display("FAIL busy_start_done_count got=%0d want=1", d_cnt); end
    total++; if (errs !== 0) begin bad++; $display("FAIL busy_start_steps got=%0d want=0", errs); end
    // Now in the DONE cycle: a start here must be taken without an IDLE cycle.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    total++; if (cur_index !== 4'd0) begin bad++; $display("FAIL done_start_index got=%h want=0", cur_index); end
    total++; if (table_out !== 16'h0000) begin bad++; $display("FAIL done_start_table got=%h want=0000", table_out); end
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL done_start_flags got=%b%b want=10", busy, done); end
    total++; if (match !== 1'b0) begin bad++; $display("FAIL done_start_match got=%b want=0", match); end
    run_sweep(1'b0, 0, 52, d_at, d_cnt, errs);
    total++; if (d_at !== 48 || d_cnt !== 1) begin bad++; $display("FAIL done_start_sweep got=%0d/%0d want=48/1", d_at, d_cnt); end
    total++; if (table_out !== 16'h0DD0 || match !== 1'b1) begin bad++; $display("FAIL done_start_result got=%h/%b want=0dd0/1", table_out, match); end
  endtask

  task automatic test_back_to_back();
    int d_first, d_second, d_cnt;
    bit drained;
    f_mode = 0;
    d_first = -1; d_second = -1; d_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        d_cnt++;
        if (d_first < 0) d_first = n;
        else if (d_second < 0) d_second = n;
      end
    end
    @(negedge clk); start = 1'b0;
    total++; if (d_first !== 48) begin bad++; $display("FAIL b2b_first got=%0d want=48", d_first); end
    total++; if (d_second !== 97) begin bad++; $display("FAIL b2b_second got=%0d want=97", d_second); end
    total++; if (d_cnt !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", d_cnt); end
    drained = 1'b0;
    for (int i = 0; i < 60 && !drained; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b0 && done === 1'b0) drained = 1'b1;
    end
    total++; if (drained !== 1'b1) begin bad++; $display("FAIL b2b_drain got=%b want=1", drained); end
  endtask

  task automatic test_mid_reset();
    int d_at, d_cnt, errs;
    bit done_seen;
    f_mode = 0;
    done_seen = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen = 1'b1;
    end
    total++; if (table_out !== 16'h00D0) begin bad++; $display("FAIL mid_partial_table got=%h want=00d0", table_out); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, done, match} !== 3'b000) begin bad++; $display("FAIL mid_async_flags got=%b want=000", {busy, done, match}); end
    total++; if (abcd_out !== 4'd0 || cur_index !== 4'd0) begin bad++; $display("FAIL mid_async_index got=%h/%h want=0/0", abcd_out, cur_index); end
    total++; if (table_out !== 16'h0000) begin bad++; $display("FAIL mid_async_table got=%h want=0000", table_out); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
    end
    total++; if (done_seen !== 1'b0) begin bad++; $display("FAIL mid_no_done got=%b want=0", done_seen); end
    run_sweep(1'b1, 0, 52, d_at, d_cnt, errs);
    total++; if (d_at !== 48 || errs !== 0) begin bad++; $display("FAIL mid_restart got=%0d/%0d want=48/0", d_at, errs); end
    total++; if (table_out !== 16'h0DD0 || match !== 1'b1) begin bad++; $display("FAIL mid_restart_result got=%h/%b want=0dd0/1", table_out, match); end
  endtask

`ifdef TTS_STUCK_FLAG_EN
  task automatic test_stuck();
    int d_at, d_cnt, errs;
    f_mode = 2;
    run_sweep(1'b1, 0, 48, d_at, d_cnt, errs);
    total++; if (table_out !== 16'h0000 || match !== 1'b0) begin bad++; $display("FAIL stuck_table got=%h/%b want=0000/0", table_out, match); end
    total++; if (stuck !== 1'b1) begin bad++; $display("FAIL stuck_set got=%b want=1", stuck); end
    repeat (4) @(posedge clk);
    #1;
    total++; if (stuck !== 1'b1) begin bad++; $display("FAIL stuck_hold got=%b want=1", stuck); end
    f_mode = 0;
    run_sweep(1'b1, 0, 52, d_at, d_cnt, errs);
    total++; if (stuck !== 1'b0) begin bad++; $display("FAIL stuck_clear got=%b want=0", stuck); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad = 0;
    f_mode = 0;
    start = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_correct();
    test_fault();
    test_start_while_busy();
    test_back_to_back();
    test_mid_reset();
`ifdef TTS_STUCK_FLAG_EN
    test_stuck();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
